// File: rtl/serv_rf_ram_bridge.sv
// Packs two serial register-file write ports into RAM words and unpacks prefetched RAM words
// into two serial read streams; writes land 1-2 cycles after a word completes, reads stream from rreq+4, no backpressure.
module serv_rf_ram_bridge #(
  parameter int width    = 8,
  parameter int W        = 1,
  parameter int csr_regs = 4,
  localparam int rw = 5 + ((csr_regs > 0) ? 1 : 0),
  localparam int ww = $clog2(32 / width),
  localparam int aw = rw + ww
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [rw-1:0]    i_wreg0,
  input  logic [rw-1:0]    i_wreg1,
  input  logic             i_wen0,
  input  logic             i_wen1,
  input  logic [W-1:0]     i_wdata0,
  input  logic [W-1:0]     i_wdata1,
  input  logic             i_rreq,
  input  logic [rw-1:0]    i_rreg0,
  input  logic [rw-1:0]    i_rreg1,
  output logic             o_ready,
  output logic [W-1:0]     o_rdata0,
  output logic [W-1:0]     o_rdata1,
  output logic [aw-1:0]    o_waddr,
  output logic [width-1:0] o_wdata,
  output logic             o_wen,
  output logic [aw-1:0]    o_raddr,
  output logic             o_ren,
  input  logic [width-1:0] i_rdata
);

  localparam int B     = width / W;
  localparam int LB    = $clog2(B);
  localparam int WCW   = 5 - $clog2(W);
  localparam int WWX   = (ww > 0) ? ww : 1;
  localparam int BEATS = 32 / W;
  localparam int RCW   = $clog2(BEATS + 3);
  localparam int LAST  = BEATS + 2;

  // A 32-bit register held in one RAM word has no word-index field.
  function automatic logic [aw-1:0] mkaddr(input logic [rw-1:0] r, input logic [WWX-1:0] w);
    logic [rw+WWX-1:0] t;
    t = {r, w};
    if (ww == 0) t = t >> 1;
    return t[aw-1:0];
  endfunction

  // ---------------------------------------------------------------- write side
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [width-1:0] pk0_q, pk0_d, pk1_q, pk1_d;
  logic [width-1:0] pk0_nx, pk1_nx;
  logic             wen_q, wen_d;
  logic [aw-1:0]    waddr_q, waddr_d;
  logic [width-1:0] wdata_q, wdata_d;
  logic             slot2_q, slot2_d;
  logic             wen1_q, wen1_d;
  logic [aw-1:0]    waddr1_q, waddr1_d;
  logic [width-1:0] wdata1_q, wdata1_d;
  logic             wbeat, wdone;
  logic [WWX-1:0]   wword;

  assign wbeat  = i_wen0 | i_wen1;
  assign wdone  = wbeat && (wcnt_q[LB-1:0] == {LB{1'b1}});
  assign wword  = WWX'(wcnt_q >> LB);
  assign pk0_nx = {i_wdata0, pk0_q[width-1:W]};
  assign pk1_nx = {i_wdata1, pk1_q[width-1:W]};

  always_comb begin
    wcnt_d   = wcnt_q;
    pk0_d    = pk0_q;
    pk1_d    = pk1_q;
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    slot2_d  = wdone;
    wen1_d   = wen1_q;
    waddr1_d = waddr1_q;
    wdata1_d = wdata1_q;
    if (wbeat) begin
      wcnt_d = wcnt_q + WCW'(1);
      pk0_d  = pk0_nx;
      pk1_d  = pk1_nx;
    end
    // Port-0 word goes out straight away; port-1 word waits one cycle in the *1 registers.
    if (wdone) begin
      wen_d    = i_wen0;
      waddr_d  = mkaddr(i_wreg0, wword);
      wdata_d  = pk0_nx;
      wen1_d   = i_wen1;
      waddr1_d = mkaddr(i_wreg1, wword);
      wdata1_d = pk1_nx;
    end else if (slot2_q) begin
      wen_d   = wen1_q;
      waddr_d = waddr1_q;
      wdata_d = wdata1_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wcnt_q   <= '0;
      pk0_q    <= '0;
      pk1_q    <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      slot2_q  <= 1'b0;
      wen1_q   <= 1'b0;
      waddr1_q <= '0;
      wdata1_q <= '0;
    end else begin
      wcnt_q   <= wcnt_d;
      pk0_q    <= pk0_d;
      pk1_q    <= pk1_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      slot2_q  <= slot2_d;
      wen1_q   <= wen1_d;
      waddr1_q <= waddr1_d;
      wdata1_q <= wdata1_d;
    end
  end

  assign o_wen   = wen_q;
  assign o_waddr = waddr_q;
  assign o_wdata = wdata_q;

  // ----------------------------------------------------------------- read side
  typedef enum logic {R_IDLE = 1'b0, R_ACTIVE = 1'b1} rstate_t;

  rstate_t          state_q, state_d;
  logic [RCW-1:0]   rcnt_q, rcnt_d;
  logic [rw-1:0]    rreg0_q, rreg0_d, rreg1_q, rreg1_d;
  logic             rvld_q, rvld_d, rsel_q, rsel_d;
  logic [width-1:0] stg0_q, stg0_d;
  logic [width-1:0] sh0_q, sh0_d, sh1_q, sh1_d;
  logic [LB-1:0]    rphase;
  logic             rd_fetch, rd_sel;

  assign rphase = rcnt_q[LB-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= R_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      R_IDLE:   if (i_rreq) state_d = R_ACTIVE;
      R_ACTIVE: if (rcnt_q == RCW'(LAST)) state_d = R_IDLE;
      default:  state_d = R_IDLE;
    endcase
  end

  // rs1 word k is fetched at rcnt = k*B and rs2 word k at k*B+1; both land before beat k*B.
  always_comb begin
    rd_fetch = 1'b0;
    rd_sel   = 1'b0;
    o_ready  = 1'b0;
    if (state_q == R_ACTIVE) begin
      rd_fetch = (rcnt_q < RCW'(BEATS)) && ({1'b0, rphase} <= (LB+1)'(1));
      rd_sel   = rphase[0];
      o_ready  = (rcnt_q == RCW'(2)) && i_rst_n;
    end
    o_ren   = rd_fetch && i_rst_n;
    o_raddr = mkaddr(rd_sel ? rreg1_q : rreg0_q, WWX'(rcnt_q >> LB));
  end

  always_comb begin
    rcnt_d  = rcnt_q;
    rreg0_d = rreg0_q;
    rreg1_d = rreg1_q;
    if (state_q == R_IDLE) begin
      if (i_rreq) begin
        rcnt_d  = '0;
        rreg0_d = i_rreg0;
        rreg1_d = i_rreg1;
      end
    end else begin
      rcnt_d = rcnt_q + RCW'(1);
    end
  end

  // rs1 data parks in stg0 for a cycle so both streams reload on the same edge.
  always_comb begin
    rvld_d = o_ren;
    rsel_d = rd_sel;
    stg0_d = (rvld_q && !rsel_q) ? i_rdata : stg0_q;
    if (rvld_q && rsel_q) begin
      sh0_d = stg0_q;
      sh1_d = i_rdata;
    end else begin
      sh0_d = sh0_q >> W;
      sh1_d = sh1_q >> W;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rcnt_q  <= '0;
      rreg0_q <= '0;
      rreg1_q <= '0;
      rvld_q  <= 1'b0;
      rsel_q  <= 1'b0;
      stg0_q  <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
    end else begin
      rcnt_q  <= rcnt_d;
      rreg0_q <= rreg0_d;
      rreg1_q <= rreg1_d;
      rvld_q  <= rvld_d;
      rsel_q  <= rsel_d;
      stg0_q  <= stg0_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
    end
  end

  assign o_rdata0 = sh0_q[W-1:0];
  assign o_rdata1 = sh1_q[W-1:0];

endmodule

// File: doc/serv_rf_ram_bridge.md
Name: serv_rf_ram_bridge

Overview:
- Sits directly downstream of the register-file interface stage.
- Converts that stage's two W-bit serial write ports and two W-bit serial read ports into word-wide accesses on a simple RAM with one read port and one write port.
- Packs W-bit beats into width-bit RAM words for writes. Prefetches and unpacks RAM words for reads, interleaving rs1/rs2 fetches so both streams run concurrently at W bits per cycle.

Parameters:
- width, 8: RAM data width. Legal values are 2..32, a power of two, with width/W >= 2.
- W, 1: serial beat width. Legal values are 1, 2 and 4.
- csr_regs, 4: number of CSRs mapped above the 32 GPRs. 0 means no CSRs; the register address is then 5 bits, otherwise 6 bits.
- Derived:
  - rw = 5 + (csr_regs>0): register address width.
  - ww = clog2(32/width): word-index width.
  - aw = rw + ww: RAM address width.

Ports:
- i_clk, in, 1: clock.
- i_rst_n, in, 1: synchronous active-low reset.
- i_wreg0, in, rw: port-0 destination register.
- i_wreg1, in, rw: port-1 destination register.
- i_wen0, in, 1: port-0 write beat valid.
- i_wen1, in, 1: port-1 write beat valid.
- i_wdata0, in, W: port-0 write beat, LSB first.
- i_wdata1, in, W: port-1 write beat, LSB first.
- i_rreq, in, 1: read request pulse.
- i_rreg0, in, rw: rs1 register, sampled when i_rreq is accepted.
- i_rreg1, in, rw: rs2/CSR register, sampled when i_rreq is accepted.
- o_ready, out, 1: one-cycle pulse; the read stream starts on the next cycle.
- o_rdata0, out, W: rs1 stream.
- o_rdata1, out, W: rs2 stream.
- o_waddr, out, aw: RAM write address, formed as {reg, word}.
- o_wdata, out, width: RAM write data.
- o_wen, out, 1: RAM write enable.
- o_raddr, out, aw: RAM read address.
- o_ren, out, 1: RAM read enable. RAM read latency is 1 cycle.
- i_rdata, in, width: RAM read data.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - Clears o_wen, o_ren, o_ready, the write beat counter wcnt, the read counter rcnt, the read-active flag and all pack/unpack registers.
  - Reset has priority over every other event.
- Write side:
  - wcnt has 5-clog2(W) bits and advances on every cycle where i_wen0|i_wen1 is high. It wraps from 32/W-1 to 0.
  - Each beat shifts i_wdata0 and i_wdata1 into separate width-bit pack registers, right-shifting with new bits entering at the MSB.
  - A word completes when the low clog2(width/W) bits of wcnt equal all-ones. On that cycle the block captures wen0, wen1, wreg0, wreg1 and the word index (upper ww bits of wcnt).
  - Slot 1, the cycle after completion: o_wen = captured wen0, o_waddr = {wreg0, word}, o_wdata = port-0 word.
  - Slot 2, the cycle after slot 1: o_wen = captured wen1, o_waddr = {wreg1, word}, o_wdata = port-1 word. The port-1 word is held one cycle to produce this slot.
  - If a port's wen is low on the completion beat, its slot issues o_wen=0.
  - Because width/W >= 2, the slots never collide with the next completion.
  - o_wen is 0 in all other cycles. o_waddr and o_wdata are don't-care when o_wen=0.
- Read side: two states, IDLE and ACTIVE.
  - IDLE:
    - i_rreq=1 latches i_rreg0/i_rreg1, clears rcnt and enters ACTIVE.
    - i_rreq while ACTIVE is ignored.
  - ACTIVE:
    - Fetch order: rs1 w0, rs2 w0, rs1 w1, rs2 w1, ... Fetches are issued at o_ren=1, o_raddr = {sel ? rreg1 : rreg0, word}.
    - Fetch timing: rs1 w0 at t+1 and rs2 w0 at t+2, where t is the i_rreq cycle. Every later word k is fetched so its data lands no later than the beat k*width/W of its stream.
    - o_ready pulses exactly at t+3.
    - From t+4, o_rdata0 and o_rdata1 present bits [W-1:0], [2W-1:W], ... on consecutive cycles for 32/W cycles. There are no stalls.
    - After the final beat (t+3+32/W) the block returns to IDLE. o_ren is 0 outside fetch cycles.
    - o_rdata0/1 are don't-care outside the stream window.
- Read and write sides are fully independent and may overlap in any cycle. A RAM write to the address being read in the same cycle returns old data; this is permitted.
- Reset during ACTIVE aborts the read. No o_ready is issued after reset, and a pending write slot is dropped.

Test Plan:
- Port-0 write, defaults: write x5=0xDEADBEEF over 32 beats with i_wen0=1 and i_wen1=0. Required RAM writes: {5,0}=EF, {5,1}=BE, {5,2}=AD, {5,3}=DE, each one cycle after its completion beat. Port-1 slots show o_wen=0.
- Dual-port write: port 0 writes reg 35=0x00000080 and port 1 writes reg 34=0x12345678. Required: interleaved pairs ({35,k},{34,k}) on consecutive cycles. Port-1 words are 78,56,34,12.
- Read: preload x5=0xDEADBEEF and x7=0x0F0F0F0F, pulse i_rreq at t. Required: o_ready=1 only at t+3. Streams from t+4 for 32 cycles reconstruct 0xDEADBEEF on o_rdata0 and 0x0F0F0F0F on o_rdata1. Second i_rreq at t+10 is ignored.
- Partial enable: i_wen0 deasserted on beat 15 of a 32-beat write, with i_wen1 held high so beats keep advancing. Required: word 1 (completion on beat 15) issues o_wen=0 in slot 1. All other words are written normally.
- Reset mid-read: i_rst_n=0 at t+2, released at t+3. Required: o_ready stays 0, o_ren=0 from the reset cycle. A fresh i_rreq at t+5 produces o_ready at t+8.
- Concurrency: a read stream and a dual-port write run in the same cycles. Required: both complete with correct data and timing.
